// File: rtl/srq_pkg.sv
// Shared definitions for the Avalon-MM PIO master: FSM state encoding and
// default bus widths.
package srq_pkg;

  localparam int SRQ_ADDR_W = 2;
  localparam int SRQ_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    LAT   = 3'd3,
    RESP  = 3'd4
  } srq_state_t;

endpackage

// File: rtl/srq_pio_master.sv
// srq_pio_master: turns single commands into one Avalon-MM transfer each,
// using active-low read/write strobes and a fixed slave read latency.
// Optional feature macro SRQ_PIO_MASTER_TIMEOUT_EN: a waitrequest watchdog
// that ends a stalled transfer with rsp_error=1. Without it the master waits
// for the slave indefinitely and rsp_error is constant 0.
module srq_pio_master
  import srq_pkg::*;
#(
  parameter int ADDR_W         = SRQ_ADDR_W,
  parameter int DATA_W         = SRQ_DATA_W,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  // Reject parameter values the datapath cannot honour.
  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
    $error("srq_pio_master: READ_LATENCY must be 0..3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("srq_pio_master: TIMEOUT_CYCLES must be at least 1");
  end

  // Last value of the latency counter; only reachable when READ_LATENCY > 0.
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  srq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic              capture;
  logic              accept;
  logic              timeout_hit;

  assign accept = (state_reg == IDLE) && cmd_valid;

`ifdef SRQ_PIO_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              err_reg;

  // The stall that would make TIMEOUT_CYCLES consecutive waitrequest cycles.
  assign timeout_hit = ((state_reg == WRITE) || (state_reg == READ)) && avm_waitrequest &&
                       (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled strobe cycles; any other cycle restarts it.
  always_comb begin
    wait_cnt_next = '0;
    if (((state_reg == WRITE) || (state_reg == READ)) && avm_waitrequest) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // Wait counter and sticky error flag for the transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign rsp_error = rsp_valid && err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  // Next-state and bus strobe decode; strobes are purely a function of state.
  always_comb begin
    state_next     = state_reg;
    lat_cnt_next   = lat_cnt_reg;
    capture        = 1'b0;
    cmd_ready      = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_read_n     = 1'b1;
    rsp_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        if (!avm_waitrequest || timeout_hit) begin
          state_next = RESP;
        end
      end
      READ: begin
        avm_chipselect = 1'b1;
        avm_read_n     = 1'b0;
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture    = 1'b1;
            state_next = RESP;
          end else begin
            lat_cnt_next = 2'd0;
            state_next   = LAT;
          end
        end else if (timeout_hit) begin
          state_next = RESP;
        end
      end
      LAT: begin
        if (lat_cnt_reg == LAT_LAST) begin
          capture      = 1'b1;
          lat_cnt_next = 2'd0;
          state_next   = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg + 2'd1;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, command capture at acceptance and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 2'd0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      if (accept) begin
        addr_reg  <= cmd_address;
        wdata_reg <= cmd_wdata;
      end
      if (capture) begin
        rdata_reg <= avm_readdata;
      end
    end
  end

  assign avm_address   = addr_reg;
  assign avm_writedata = wdata_reg;
  assign rsp_rdata     = rdata_reg;

endmodule

// File: tb/tb_srq_pio_master.sv
// Bench for srq_pio_master: two instances (READ_LATENCY 0 and 2, the second
// with TIMEOUT_CYCLES=4) run directed command sequences. A cycle-indexed
// expectation table is built from transaction-level timing rules and checked
// every cycle; a few literal checks pin the table's timing.
module tb_srq_pio_master;

  localparam int N = 100;

`ifdef SRQ_PIO_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, cmd_valid, cmd_write, avm_waitrequest;
  logic [1:0]  cmd_address [2];
  logic [31:0] cmd_wdata [2];
  logic [31:0] avm_readdata [2];
  logic [1:0]  cmd_ready, avm_chipselect, avm_write_n, avm_read_n, rsp_valid, rsp_error;
  logic [1:0]  avm_address [2];
  logic [31:0] avm_writedata [2];
  logic [31:0] rsp_rdata [2];

  srq_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_lat0 (
    .clk(clk), .reset(reset[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_address(cmd_address[0]), .cmd_wdata(cmd_wdata[0]),
    .avm_address(avm_address[0]), .avm_chipselect(avm_chipselect[0]),
    .avm_write_n(avm_write_n[0]), .avm_read_n(avm_read_n[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
    .avm_waitrequest(avm_waitrequest[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  srq_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT_CYCLES(4)) u_lat2 (
    .clk(clk), .reset(reset[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_address(cmd_address[1]), .cmd_wdata(cmd_wdata[1]),
    .avm_address(avm_address[1]), .avm_chipselect(avm_chipselect[1]),
    .avm_write_n(avm_write_n[1]), .avm_read_n(avm_read_n[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
    .avm_waitrequest(avm_waitrequest[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  // stimulus tables
  logic        s_reset [2][N];
  logic        s_valid [2][N];
  logic        s_write [2][N];
  logic [1:0]  s_addr  [2][N];
  logic [31:0] s_wdata [2][N];
  logic        s_wait  [2][N];
  logic [31:0] s_rdata [2][N];
  // expectation tables
  logic        e_chk [2][N];
  logic        e_ready [2][N];
  logic        e_cs [2][N];
  logic        e_wn [2][N];
  logic        e_rn [2][N];
  logic        e_valid [2][N];
  logic        e_err [2][N];
  logic [31:0] e_rdata [2][N];
  logic        e_chk_addr [2][N];
  logic [1:0]  e_addr [2][N];
  logic        e_chk_wdata [2][N];
  logic [31:0] e_wdata [2][N];
  // observed outputs
  logic        o_ready [2][N];
  logic        o_cs [2][N];
  logic        o_wn [2][N];
  logic        o_rn [2][N];
  logic        o_valid [2][N];
  logic        o_err [2][N];
  logic [31:0] o_rdata [2][N];
  logic [31:0] o_wdata [2][N];

  logic [31:0] m_rdata [2];
  int a23 [2];
  int a24 [2];
  int a25 [2];
  int at [2];
  int ar [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 255 : 4;
  endfunction

  task automatic check(input string name, input int i, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%08h expected 0x%08h", name, i, c, act, exp);
    end
  endtask

  task automatic idle(input int i, input int from, input int to);
    for (int c = from; c < to; c++) begin
      e_chk[i][c] = 1; e_ready[i][c] = 1; e_cs[i][c] = 0; e_wn[i][c] = 1; e_rn[i][c] = 1;
      e_valid[i][c] = 0; e_err[i][c] = 0; e_rdata[i][c] = m_rdata[i];
      e_chk_addr[i][c] = 0; e_chk_wdata[i][c] = 0;
    end
  endtask

  // busy cycle: not ready, strobes off, an unrelated command offered (must be ignored)
  task automatic busy(input int i, input int c, input logic [1:0] addr,
                      input logic [31:0] wdata, input bit wr);
    e_chk[i][c] = 1; e_ready[i][c] = 0; e_cs[i][c] = 0; e_wn[i][c] = 1; e_rn[i][c] = 1;
    e_valid[i][c] = 0; e_err[i][c] = 0; e_rdata[i][c] = m_rdata[i];
    e_chk_addr[i][c] = 0; e_chk_wdata[i][c] = 0;
    s_valid[i][c] = 1; s_write[i][c] = ~wr; s_addr[i][c] = ~addr; s_wdata[i][c] = ~wdata;
    s_wait[i][c] = 0;
  endtask

  // One command offered at cycle a; nw stalled strobe cycles before the slave accepts.
  task automatic txn(input int i, input int a, input bit wr, input logic [1:0] addr,
                     input logic [31:0] wdata, input int nw, input logic [31:0] rdata,
                     output int nxt);
    int ns, c, cap, lat;
    bit tmo;
    lat = lat_of(i);
    idle(i, a, a + 1);
    s_valid[i][a] = 1; s_write[i][a] = wr; s_addr[i][a] = addr; s_wdata[i][a] = wdata;
    tmo = TO_EN && (nw >= to_of(i));
    ns = tmo ? to_of(i) : nw + 1;
    for (int k = 0; k < ns; k++) begin
      c = a + 1 + k;
      busy(i, c, addr, wdata, wr);
      s_wait[i][c] = (k < nw);
      e_cs[i][c] = 1; e_wn[i][c] = !wr; e_rn[i][c] = wr;
      e_chk_addr[i][c] = 1; e_addr[i][c] = addr;
      e_chk_wdata[i][c] = wr; e_wdata[i][c] = wdata;
    end
    c = a + 1 + ns;
    if (!wr && !tmo) begin
      for (int k = 0; k < lat; k++) busy(i, c + k, addr, wdata, wr);
      cap = (lat == 0) ? (a + ns) : (c + lat - 1);
      s_rdata[i][cap] = rdata;
      c = c + lat;
      m_rdata[i] = rdata;
    end
    busy(i, c, addr, wdata, wr);
    e_valid[i][c] = 1; e_err[i][c] = tmo; e_rdata[i][c] = m_rdata[i];
    nxt = c + 1;
  endtask

  // Read stalled by waitrequest, reset asserted in its k-th strobe cycle.
  task automatic rst_read(input int i, input int a, input logic [1:0] addr,
                          input int k, output int nxt);
    int c, r;
    idle(i, a, a + 1);
    s_valid[i][a] = 1; s_write[i][a] = 0; s_addr[i][a] = addr; s_wdata[i][a] = 32'h0;
    for (int j = 0; j <= k; j++) begin
      c = a + 1 + j;
      busy(i, c, addr, 32'h0, 1'b0);
      s_wait[i][c] = 1;
      e_cs[i][c] = 1; e_rn[i][c] = 0; e_chk_addr[i][c] = 1; e_addr[i][c] = addr;
    end
    r = a + 1 + k;
    s_reset[i][r] = 1;
    m_rdata[i] = 32'h0;
    idle(i, r + 1, r + 2);
    e_chk_addr[i][r + 1] = 1; e_addr[i][r + 1] = 2'd0;
    e_chk_wdata[i][r + 1] = 1; e_wdata[i][r + 1] = 32'h0;
    nxt = r + 2;
  endtask

  task automatic build(input int i);
    int t;
    for (int c = 0; c < N; c++) begin
      s_reset[i][c] = 0; s_valid[i][c] = 0; s_write[i][c] = 0; s_addr[i][c] = 0;
      s_wdata[i][c] = 0; s_wait[i][c] = 0; s_rdata[i][c] = 32'hDEAD_0000 | 32'(c);
      e_chk[i][c] = 0;
    end
    m_rdata[i] = 32'h0;
    s_reset[i][0] = 1; s_reset[i][1] = 1;
    idle(i, 1, 3);
    e_chk_addr[i][1] = 1; e_addr[i][1] = 0; e_chk_wdata[i][1] = 1; e_wdata[i][1] = 0;
    t = 3;
    a23[i] = t; txn(i, t, 1'b1, 2'd0, 32'h0000_05A5, 0, 32'h0, t);
    a24[i] = t; txn(i, t, 1'b0, 2'd1, 32'h1111_1111, 0, 32'h0000_07FF, t);
    a25[i] = t; txn(i, t, 1'b0, 2'd2, 32'h2222_2222, 3, 32'hCAFE_0125, t);
    txn(i, t, 1'b1, 2'd3, 32'h1234_5678, 2, 32'h0, t);
    txn(i, t, 1'b0, 2'd3, 32'h0, 1, 32'h0BAD_F00D, t);
    txn(i, t, 1'b1, 2'd1, 32'hFFFF_FFFF, 0, 32'h0, t);
    idle(i, t, t + 2); t = t + 2;
    at[i] = t; txn(i, t, 1'b0, 2'd2, 32'h0, 6, 32'h55AA_55AA, t);
    idle(i, t, t + 1); t = t + 1;
    ar[i] = t; rst_read(i, t, 2'd1, 2, t);
    txn(i, t, 1'b1, 2'd2, 32'h0000_0001, 0, 32'h0, t);
    idle(i, t, N);
  endtask

  // per-cycle comparison against the expectation table
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        o_ready[i][cyc] = cmd_ready[i]; o_cs[i][cyc] = avm_chipselect[i];
        o_wn[i][cyc] = avm_write_n[i]; o_rn[i][cyc] = avm_read_n[i];
        o_valid[i][cyc] = rsp_valid[i]; o_err[i][cyc] = rsp_error[i];
        o_rdata[i][cyc] = rsp_rdata[i]; o_wdata[i][cyc] = avm_writedata[i];
        if (e_chk[i][cyc]) begin
          check("cmd_ready", i, cyc, 32'(cmd_ready[i]), 32'(e_ready[i][cyc]));
          check("chipselect", i, cyc, 32'(avm_chipselect[i]), 32'(e_cs[i][cyc]));
          check("write_n", i, cyc, 32'(avm_write_n[i]), 32'(e_wn[i][cyc]));
          check("read_n", i, cyc, 32'(avm_read_n[i]), 32'(e_rn[i][cyc]));
          check("rsp_valid", i, cyc, 32'(rsp_valid[i]), 32'(e_valid[i][cyc]));
          check("rsp_error", i, cyc, 32'(rsp_error[i]), 32'(e_err[i][cyc]));
          check("rsp_rdata", i, cyc, rsp_rdata[i], e_rdata[i][cyc]);
          if (e_chk_addr[i][cyc])
            check("avm_address", i, cyc, 32'(avm_address[i]), 32'(e_addr[i][cyc]));
          if (e_chk_wdata[i][cyc])
            check("avm_writedata", i, cyc, avm_writedata[i], e_wdata[i][cyc]);
        end
      end
    end
  end

  initial begin
    int cnt, r;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1; cmd_valid[i] = 0; cmd_write[i] = 0; cmd_address[i] = 0;
      cmd_wdata[i] = 0; avm_waitrequest[i] = 0; avm_readdata[i] = 0;
    end
    build(0);
    build(1);
    run = 1'b1;
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      for (int i = 0; i < 2; i++) begin
        reset[i] = s_reset[i][c]; cmd_valid[i] = s_valid[i][c]; cmd_write[i] = s_write[i][c];
        cmd_address[i] = s_addr[i][c]; cmd_wdata[i] = s_wdata[i][c];
        avm_waitrequest[i] = s_wait[i][c]; avm_readdata[i] = s_rdata[i][c];
      end
    end
    @(negedge clk);
    #1;
    run = 1'b0;

    // literal expectations pinning the table
    for (int i = 0; i < 2; i++) begin
      check("lit_wr_strobe", i, a23[i] + 1, 32'(o_wn[i][a23[i] + 1]), 32'd0);
      check("lit_wr_data", i, a23[i] + 1, o_wdata[i][a23[i] + 1], 32'h0000_05A5);
      check("lit_wr_resp", i, a23[i] + 2, 32'(o_valid[i][a23[i] + 2]), 32'd1);
      check("lit_wr_err", i, a23[i] + 2, 32'(o_err[i][a23[i] + 2]), 32'd0);
      check("lit_busy_ready", i, a23[i] + 2, 32'(o_ready[i][a23[i] + 2]), 32'd0);
      r = ar[i] + 3;
      check("lit_rst_cs", i, r + 1, 32'(o_cs[i][r + 1]), 32'd0);
      check("lit_rst_rn", i, r + 1, 32'(o_rn[i][r + 1]), 32'd1);
      check("lit_rst_novalid", i, r, 32'(o_valid[i][r] | o_valid[i][r + 1]), 32'd0);
      check("lit_rst_ready", i, r + 1, 32'(o_ready[i][r + 1]), 32'd1);
      check("lit_rst_rdata", i, r + 1, o_rdata[i][r + 1], 32'h0);
    end
    check("lit_rd0_valid", 0, a24[0] + 2, 32'(o_valid[0][a24[0] + 2]), 32'd1);
    check("lit_rd0_rdata", 0, a24[0] + 2, o_rdata[0][a24[0] + 2], 32'h0000_07FF);
    cnt = 0;
    for (int c = a25[1] + 1; c <= a25[1] + 8; c++) if (o_rn[1][c] == 1'b0) cnt++;
    check("lit_rd2_rn_low", 1, a25[1], cnt, 4);
    cnt = 0;
    for (int c = a25[1] + 1; c <= a25[1] + 7; c++) if (o_valid[1][c]) cnt++;
    check("lit_rd2_one_valid", 1, a25[1], cnt, 1);
    check("lit_rd2_valid", 1, a25[1] + 7, 32'(o_valid[1][a25[1] + 7]), 32'd1);
    check("lit_rd2_rdata", 1, a25[1] + 7, o_rdata[1][a25[1] + 7], 32'hCAFE_0125);
`ifdef SRQ_PIO_MASTER_TIMEOUT_EN
    check("lit_to_valid", 1, at[1] + 5, 32'(o_valid[1][at[1] + 5]), 32'd1);
    check("lit_to_err", 1, at[1] + 5, 32'(o_err[1][at[1] + 5]), 32'd1);
    check("lit_to_rdata", 1, at[1] + 5, o_rdata[1][at[1] + 5], 32'h0BAD_F00D);
`else
    check("lit_stall_valid", 1, at[1] + 10, 32'(o_valid[1][at[1] + 10]), 32'd1);
    check("lit_stall_err", 1, at[1] + 10, 32'(o_err[1][at[1] + 10]), 32'd0);
    check("lit_stall_rdata", 1, at[1] + 10, o_rdata[1][at[1] + 10], 32'h55AA_55AA);
`endif
    check("lit_stall0_rdata", 0, at[0] + 8, o_rdata[0][at[0] + 8], 32'h55AA_55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
